serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 206 ++++++++++++++++++++
 tb/tb_serial_adder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle adder/subtractor that processes its operands CHUNK bits per
// clock, least-significant chunk first, rippling the carry between cycles
// through a single stored carry bit.  A full operation occupies the RUN state
// for exactly NCH = WIDTH/CHUNK cycles, followed by a single DONE cycle.
//
// Parameters
//   WIDTH     operand / result width in bits (>= 2)
//   CHUNK     bits added per clock; WIDTH must be a multiple of CHUNK
//
// Ports
//   clk       sole clock, all state updates on the rising edge
//   rst       synchronous active-high reset (priority over start)
//   start     begin an operation; accepted in IDLE or DONE, ignored in RUN
//   a, b      operands, captured when start is accepted
//   cin       carry-in for add mode, captured with the operands
//   sub       0: a + b + cin, 1: a - b (computed as a + ~b + 1, cin ignored)
//   busy      high while the FSM is in RUN
//   done      one-cycle pulse (state DONE) marking the result valid
//   sum       result, low WIDTH bits; partial bits may appear during RUN
//   cout      carry out of bit WIDTH-1 (subtract: 1 means no borrow)
//   overflow  two's-complement signed overflow of the operation
//   zero      high when the final sum is zero
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NCH = WIDTH / CHUNK;
    // Chunk counter width; a single-chunk configuration still needs one bit.
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;       // already inverted for subtraction
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry_reg;
    logic [KW-1:0]    k_reg;
    logic             cout_reg;
    logic             overflow_reg;
    logic             zero_reg;

    logic             accept;
    logic             last_chunk;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic [CHUNK:0]   c;           // c[i] = carry into bit i of the chunk

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    assign accept     = start && (state_reg != RUN);
    assign last_chunk = (state_reg == RUN) && (k_reg == KW'(NCH - 1));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Back-to-back start skips IDLE entirely.
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Select the current chunk of each latched operand
    // -----------------------------------------------------------------------
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCH; i++) begin
            if (k_reg == KW'(i)) begin
                a_chunk = a_reg[i*CHUNK +: CHUNK];
                b_chunk = b_reg[i*CHUNK +: CHUNK];
            end
        end
    end

    // -----------------------------------------------------------------------
    // CHUNK-bit ripple adder seeded by the stored carry.  The carry into the
    // chunk's top bit is kept so the signed overflow of the final chunk can
    // be formed as carry-in XOR carry-out of bit WIDTH-1.
    // -----------------------------------------------------------------------
    assign c[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            assign s_chunk[gi] = a_chunk[gi] ^ b_chunk[gi] ^ c[gi];
            assign c[gi+1]     = (a_chunk[gi] & b_chunk[gi])
                               | (c[gi] & (a_chunk[gi] ^ b_chunk[gi]));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Merge the chunk result into its slot of the running sum
    // -----------------------------------------------------------------------
    always_comb begin
        sum_next = sum_reg;
        for (int i = 0; i < NCH; i++) begin
            if (k_reg == KW'(i)) begin
                sum_next[i*CHUNK +: CHUNK] = s_chunk;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg        <= '0;
            b_reg        <= '0;
            sum_reg      <= '0;
            carry_reg    <= 1'b0;
            k_reg        <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b once here and seed carry.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            k_reg     <= '0;
            sum_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_reg   <= sum_next;
            carry_reg <= c[CHUNK];
            if (last_chunk) begin
                k_reg        <= '0;
                // Flags change only here so they hold through DONE/IDLE and
                // keep their old values while a new operation is running.
                cout_reg     <= c[CHUNK];
                overflow_reg <= c[CHUNK] ^ c[CHUNK-1];
                zero_reg     <= (sum_next == '0);
            end else begin
                k_reg <= k_reg + KW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy     = (state_reg == RUN);
    assign done     = (state_reg == DONE);
    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = overflow_reg;
    assign zero     = zero_reg;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed bench for serial_adder.  Four WIDTH=8 instances are built with
// CHUNK = 1, 2, 4, 8 sharing clock, reset and operand inputs; each has its
// own start line.  Expected results are hand-computed constants, plus a
// short random pass checked against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int NI = 4;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;

    logic       start_w    [NI];
    logic       busy_w     [NI];
    logic       done_w     [NI];
    logic [7:0] sum_w      [NI];
    logic       cout_w     [NI];
    logic       overflow_w [NI];
    logic       zero_w     [NI];

    int n_tests = 0;
    int n_fail  = 0;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            serial_adder #(
                .WIDTH (8),
                .CHUNK (1 << gi)
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .start    (start_w[gi]),
                .a        (a),
                .b        (b),
                .cin      (cin),
                .sub      (sub),
                .busy     (busy_w[gi]),
                .done     (done_w[gi]),
                .sum      (sum_w[gi]),
                .cout     (cout_w[gi]),
                .overflow (overflow_w[gi]),
                .zero     (zero_w[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete operation on instance idx; inputs are scrambled right
    // after acceptance to show the latched copies are what get used.
    task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic sv,
                          input logic [7:0] es, input logic ec, input logic eo,
                          input logic ez, input int ecyc);
        int nb;
        int guard;
        @(negedge clk);
        a = av; b = bv; cin = cv; sub = sv;
        start_w[idx] = 1'b1;
        @(negedge clk);
        start_w[idx] = 1'b0;
        a = ~av; b = ~bv; cin = ~cv; sub = ~sv;
        nb = 0;
        guard = 0;
        while (done_w[idx] !== 1'b1 && guard < 40) begin
            if (busy_w[idx] === 1'b1) nb++;
            guard++;
            @(negedge clk);
        end
        check("done_seen",   {31'd0, done_w[idx]}, 32'd1);
        check("busy_cycles", nb, ecyc);
        check("sum",         {24'd0, sum_w[idx]}, {24'd0, es});
        check("cout",        {31'd0, cout_w[idx]}, {31'd0, ec});
        check("overflow",    {31'd0, overflow_w[idx]}, {31'd0, eo});
        check("zero",        {31'd0, zero_w[idx]}, {31'd0, ez});
        $display("[TB] inst %0d a=%02h b=%02h cin=%0b sub=%0b -> sum=%02h cout=%0b ovf=%0b zero=%0b busy=%0d",
                 idx, av, bv, cv, sv, sum_w[idx], cout_w[idx], overflow_w[idx], zero_w[idx], nb);
        @(negedge clk);
        check("done_pulse",  {31'd0, done_w[idx]}, 32'd0);
        check("idle_busy",   {31'd0, busy_w[idx]}, 32'd0);
        check("sum_hold",    {24'd0, sum_w[idx]}, {24'd0, es});
    endtask

    initial begin
        int ndone;
        int last_done;
        logic [7:0] ra, rb, bb, es;
        logic       rc, rs, c0, ec, eo;
        logic [8:0] full;

        rst = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < NI; i++) start_w[i] = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_busy", {31'd0, busy_w[i]}, 32'd0);
            check("rst_done", {31'd0, done_w[i]}, 32'd0);
            check("rst_sum",  {24'd0, sum_w[i]}, 32'd0);
            check("rst_flags", {29'd0, cout_w[i], overflow_w[i], zero_w[i]}, 32'd0);
        end
        $display("[TB] reset state checked");
        rst = 1'b0;

        // Directed vectors
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 8);
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8);
        run_op(2, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 2);
        run_op(1, 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0, 4);
        run_op(3, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1);
        run_op(1, 8'h64, 8'h64, 1'b0, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0, 4);
        run_op(2, 8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 2);
        run_op(0, 8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8);

        // Restart mid-run is ignored, reset aborts with no done pulse.
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0;
        start_w[0] = 1'b1;
        @(negedge clk);                      // RUN cycle 1
        start_w[0] = 1'b0;
        @(negedge clk);                      // RUN cycle 2
        @(negedge clk);                      // RUN cycle 3
        start_w[0] = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk);                      // RUN cycle 4
        start_w[0] = 1'b0;
        check("ignored_start_busy", {31'd0, busy_w[0]}, 32'd1);
        @(negedge clk);                      // RUN cycle 5
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",  {31'd0, busy_w[0]}, 32'd0);
        check("abort_done",  {31'd0, done_w[0]}, 32'd0);
        check("abort_sum",   {24'd0, sum_w[0]}, 32'd0);
        check("abort_flags", {29'd0, cout_w[0], overflow_w[0], zero_w[0]}, 32'd0);
        start_w[0] = 1'b1;                   // reset must win over start
        @(negedge clk);
        check("rst_priority_busy", {31'd0, busy_w[0]}, 32'd0);
        start_w[0] = 1'b0;
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_w[0] === 1'b1) ndone++;
        end
        check("abort_no_done", ndone, 0);
        $display("[TB] abort sequence done pulses after reset=%0d", ndone);

        // Start held high: back-to-back operations every 5 cycles.
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b1; sub = 1'b0;
        start_w[1] = 1'b1;
        ndone = 0;
        last_done = 0;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (done_w[1] === 1'b1) begin
                ndone++;
                check("b2b_sum", {24'd0, sum_w[1]}, 32'h31);
                check("b2b_period", t - last_done, 5);
                $display("[TB] back-to-back done #%0d at cycle %0d sum=%02h", ndone, t, sum_w[1]);
                last_done = t;
            end
        end
        start_w[1] = 1'b0;
        check("b2b_done_count", ndone, 3);
        repeat (8) @(negedge clk);

        // Random pass against an arithmetic reference.
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 6; n++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                rs = 1'($urandom);
                bb = rs ? ~rb : rb;
                c0 = rs ? 1'b1 : rc;
                full = {1'b0, ra} + {1'b0, bb} + {8'd0, c0};
                es = full[7:0];
                ec = full[8];
                eo = (ra[7] == bb[7]) && (es[7] != ra[7]);
                run_op(i, ra, rb, rc, rs, es, ec, eo, (es == 8'h00), 8 >> i);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
